// File: rtl/popcount.sv
// Population count of a bit vector: number of set bits in data_i.
module popcount #(
   parameter int INPUT_WIDTH = 16
) (
   input  logic [INPUT_WIDTH-1:0]         data_i,
   output logic [$clog2(INPUT_WIDTH):0]   popcount_o
);

   localparam int CntWidth = $clog2(INPUT_WIDTH) + 1;

   // Ripple sum of all input bits; the count is wide enough to hold INPUT_WIDTH.
   always_comb begin
      popcount_o = '0;
      for (int i = 0; i < INPUT_WIDTH; i++) begin
         popcount_o = popcount_o + CntWidth'(data_i[i]);
      end
   end

endmodule

// File: rtl/mask_index_serializer.sv
// Expands a mask into a stream of set-bit indices, LSB first, one per
// idx handshake, while reporting the mask's popcount and indices still due.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no mask held; ready for a new mask (unless flushing)
// ITER  | emitting lowest set bit of mask_q until the last one is taken
module mask_index_serializer #(
   parameter int WIDTH = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        flush_i,
   input  logic [WIDTH-1:0]            mask_i,
   input  logic                        mask_valid_i,
   output logic                        mask_ready_o,
   output logic [$clog2(WIDTH)-1:0]    idx_o,
   output logic                        idx_valid_o,
   input  logic                        idx_ready_i,
   output logic                        idx_last_o,
   output logic [$clog2(WIDTH):0]      count_o,
   output logic [$clog2(WIDTH):0]      remaining_o,
   output logic                        zero_mask_o
);

   localparam int IdxWidth = $clog2(WIDTH);
   localparam int CntWidth = $clog2(WIDTH) + 1;

   typedef enum logic {
      IDLE = 1'b0,
      ITER = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    mask_q, mask_d;
   logic [CntWidth-1:0] count_q, count_d;
   logic [CntWidth-1:0] remaining_q, remaining_d;
   logic                zero_mask_q, zero_mask_d;

   logic [CntWidth-1:0] mask_cnt;
   logic [IdxWidth-1:0] low_idx;
   logic                accept;
   logic                idx_hs;

   popcount #(
      .INPUT_WIDTH (WIDTH)
   ) u_popcount (
      .data_i     (mask_i),
      .popcount_o (mask_cnt)
   );

   // Priority encoder: position of the lowest set bit of the held mask.
   always_comb begin
      low_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            low_idx = IdxWidth'(i);
         end
      end
   end

   // Next-state, datapath updates and handshake outputs.
   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      count_d      = count_q;
      remaining_d  = remaining_q;
      zero_mask_d  = 1'b0;

      mask_ready_o = (state_q == IDLE) && !flush_i;
      idx_valid_o  = (state_q == ITER);
      idx_o        = (state_q == ITER) ? low_idx : '0;
      idx_last_o   = (state_q == ITER) && (remaining_q == CntWidth'(1));
      accept       = mask_valid_i && mask_ready_o;
      idx_hs       = idx_valid_o && idx_ready_i;

      if (flush_i) begin
         // Abort wins over any handshake this cycle; the count of the
         // aborted mask stays visible.
         state_d     = IDLE;
         mask_d      = '0;
         remaining_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  count_d     = mask_cnt;
                  remaining_d = mask_cnt;
                  if (mask_i == '0) begin
                     mask_d      = '0;
                     zero_mask_d = 1'b1;
                  end else begin
                     mask_d  = mask_i;
                     state_d = ITER;
                  end
               end
            end
            ITER: begin
               if (idx_hs) begin
                  // Clearing the lowest set bit: x & (x - 1).
                  mask_d      = mask_q & (mask_q - WIDTH'(1));
                  remaining_d = remaining_q - CntWidth'(1);
                  if (idx_last_o) begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign count_o     = count_q;
   assign remaining_o = remaining_q;
   assign zero_mask_o = zero_mask_q;

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         count_q     <= '0;
         remaining_q <= '0;
         zero_mask_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         zero_mask_q <= zero_mask_d;
      end
   end

endmodule

// File: tb/tb_mask_index_serializer.sv
// Directed bench for mask_index_serializer (WIDTH=16).
module tb_mask_index_serializer;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic [15:0] mask_i = '0;
   logic        mask_valid_i = 1'b0;
   logic        mask_ready_o;
   logic [3:0]  idx_o;
   logic        idx_valid_o;
   logic        idx_ready_i = 1'b0;
   logic        idx_last_o;
   logic [4:0]  count_o;
   logic [4:0]  remaining_o;
   logic        zero_mask_o;

   int total = 0;
   int bad = 0;

   mask_index_serializer #(.WIDTH(16)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .mask_i       (mask_i),
      .mask_valid_i (mask_valid_i),
      .mask_ready_o (mask_ready_o),
      .idx_o        (idx_o),
      .idx_valid_o  (idx_valid_o),
      .idx_ready_i  (idx_ready_i),
      .idx_last_o   (idx_last_o),
      .count_o      (count_o),
      .remaining_o  (remaining_o),
      .zero_mask_o  (zero_mask_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Drive a mask for one cycle (it is accepted at the coming edge).
   task automatic offer(input logic [15:0] m);
      mask_i       = m;
      mask_valid_i = 1'b1;
      tick();
      mask_valid_i = 1'b0;
      mask_i       = '0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      #1;
      total++; if (mask_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", mask_ready_o); end
      total++; if (idx_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", idx_valid_o); end
      total++; if (count_o !== 5'd0 || remaining_o !== 5'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", count_o, remaining_o); end
      tick();
      rst_ni = 1'b1;
      tick();
      // Reset asserted mid-ITER must clear outputs immediately.
      idx_ready_i = 1'b0;
      offer(16'h00FF);
      tick();
      total++; if (idx_valid_o !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%0b exp=1", idx_valid_o); end
      rst_ni = 1'b0;
      #1;
      total++; if (mask_ready_o !== 1'b1 || idx_valid_o !== 1'b0) begin bad++; $display("FAIL midreset_hs got ready=%0b valid=%0b exp 1/0", mask_ready_o, idx_valid_o); end
      total++; if (count_o !== 5'd0 || remaining_o !== 5'd0) begin bad++; $display("FAIL midreset_counts got=%0d/%0d exp=0/0", count_o, remaining_o); end
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_stream_8421();
      logic [3:0] exp_idx [4];
      exp_idx[0] = 4'd0; exp_idx[1] = 4'd5; exp_idx[2] = 4'd10; exp_idx[3] = 4'd15;
      idx_ready_i = 1'b1;
      total++; if (mask_ready_o !== 1'b1) begin bad++; $display("FAIL s8421_ready_idle got=%0b exp=1", mask_ready_o); end
      offer(16'h8421);
      for (int i = 0; i < 4; i++) begin
         total++; if (idx_valid_o !== 1'b1 || idx_o !== exp_idx[i]) begin bad++; $display("FAIL s8421_idx%0d got v=%0b idx=%0d exp idx=%0d", i, idx_valid_o, idx_o, exp_idx[i]); end
         total++; if (remaining_o !== 5'(4 - i) || count_o !== 5'd4) begin bad++; $display("FAIL s8421_cnt%0d got rem=%0d cnt=%0d exp rem=%0d cnt=4", i, remaining_o, count_o, 4 - i); end
         total++; if (idx_last_o !== (i == 3)) begin bad++; $display("FAIL s8421_last%0d got=%0b exp=%0b", i, idx_last_o, (i == 3)); end
         total++; if (mask_ready_o !== 1'b0) begin bad++; $display("FAIL s8421_ready_busy%0d got=%0b exp=0", i, mask_ready_o); end
         tick();
      end
      total++; if (mask_ready_o !== 1'b1 || idx_valid_o !== 1'b0) begin bad++; $display("FAIL s8421_done got ready=%0b valid=%0b exp 1/0", mask_ready_o, idx_valid_o); end
      total++; if (remaining_o !== 5'd0 || count_o !== 5'd4) begin bad++; $display("FAIL s8421_done_cnt got rem=%0d cnt=%0d exp 0/4", remaining_o, count_o); end
   endtask

   task automatic test_stall();
      idx_ready_i = 1'b0;
      offer(16'h0006);
      for (int i = 0; i < 3; i++) begin
         total++; if (idx_valid_o !== 1'b1 || idx_o !== 4'd1 || remaining_o !== 5'd2 || idx_last_o !== 1'b0) begin
            bad++; $display("FAIL stall%0d got v=%0b idx=%0d rem=%0d last=%0b exp 1/1/2/0", i, idx_valid_o, idx_o, remaining_o, idx_last_o);
         end
         tick();
      end
      idx_ready_i = 1'b1;
      #1;
      total++; if (idx_o !== 4'd1 || remaining_o !== 5'd2) begin bad++; $display("FAIL stall_release got idx=%0d rem=%0d exp 1/2", idx_o, remaining_o); end
      tick();
      total++; if (idx_valid_o !== 1'b1 || idx_o !== 4'd2 || idx_last_o !== 1'b1 || remaining_o !== 5'd1) begin
         bad++; $display("FAIL stall_second got v=%0b idx=%0d last=%0b rem=%0d exp 1/2/1/1", idx_valid_o, idx_o, idx_last_o, remaining_o);
      end
      tick();
      total++; if (idx_valid_o !== 1'b0 || mask_ready_o !== 1'b1) begin bad++; $display("FAIL stall_done got v=%0b ready=%0b exp 0/1", idx_valid_o, mask_ready_o); end
   endtask

   task automatic test_zero_mask();
      total++; if (zero_mask_o !== 1'b0) begin bad++; $display("FAIL zero_pre got=%0b exp=0", zero_mask_o); end
      offer(16'h0000);
      total++; if (zero_mask_o !== 1'b1) begin bad++; $display("FAIL zero_pulse got=%0b exp=1", zero_mask_o); end
      total++; if (idx_valid_o !== 1'b0 || count_o !== 5'd0 || remaining_o !== 5'd0 || mask_ready_o !== 1'b1) begin
         bad++; $display("FAIL zero_state got v=%0b cnt=%0d rem=%0d ready=%0b exp 0/0/0/1", idx_valid_o, count_o, remaining_o, mask_ready_o);
      end
      tick();
      total++; if (zero_mask_o !== 1'b0 || idx_valid_o !== 1'b0) begin bad++; $display("FAIL zero_after got pulse=%0b v=%0b exp 0/0", zero_mask_o, idx_valid_o); end
   endtask

   task automatic test_full_mask();
      idx_ready_i = 1'b1;
      offer(16'hFFFF);
      total++; if (count_o !== 5'd16) begin bad++; $display("FAIL full_count got=%0d exp=16", count_o); end
      for (int i = 0; i < 16; i++) begin
         total++; if (idx_valid_o !== 1'b1 || idx_o !== 4'(i) || remaining_o !== 5'(16 - i) || idx_last_o !== (i == 15)) begin
            bad++; $display("FAIL full_idx%0d got v=%0b idx=%0d rem=%0d last=%0b exp idx=%0d rem=%0d", i, idx_valid_o, idx_o, remaining_o, idx_last_o, i, 16 - i);
         end
         tick();
      end
      total++; if (idx_valid_o !== 1'b0 || mask_ready_o !== 1'b1 || count_o !== 5'd16) begin
         bad++; $display("FAIL full_done got v=%0b ready=%0b cnt=%0d exp 0/1/16", idx_valid_o, mask_ready_o, count_o);
      end
   endtask

   task automatic test_flush();
      idx_ready_i = 1'b1;
      offer(16'h00F0);
      total++; if (idx_o !== 4'd4) begin bad++; $display("FAIL flush_first got=%0d exp=4", idx_o); end
      tick();
      total++; if (idx_o !== 4'd5) begin bad++; $display("FAIL flush_second got=%0d exp=5", idx_o); end
      tick();
      flush_i      = 1'b1;
      mask_i       = 16'h0001;
      mask_valid_i = 1'b1;
      #1;
      total++; if (mask_ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b exp=0", mask_ready_o); end
      tick();
      flush_i = 1'b0;
      #1;
      total++; if (idx_valid_o !== 1'b0 || remaining_o !== 5'd0 || count_o !== 5'd4) begin
         bad++; $display("FAIL flush_idle got v=%0b rem=%0d cnt=%0d exp 0/0/4", idx_valid_o, remaining_o, count_o);
      end
      total++; if (mask_ready_o !== 1'b1) begin bad++; $display("FAIL flush_ready_after got=%0b exp=1", mask_ready_o); end
      tick();
      mask_valid_i = 1'b0;
      mask_i       = '0;
      total++; if (idx_valid_o !== 1'b1 || idx_o !== 4'd0 || idx_last_o !== 1'b1 || count_o !== 5'd1 || remaining_o !== 5'd1) begin
         bad++; $display("FAIL flush_next_mask got v=%0b idx=%0d last=%0b cnt=%0d rem=%0d exp 1/0/1/1/1", idx_valid_o, idx_o, idx_last_o, count_o, remaining_o);
      end
      tick();
      total++; if (idx_valid_o !== 1'b0 || mask_ready_o !== 1'b1) begin bad++; $display("FAIL flush_end got v=%0b ready=%0b exp 0/1", idx_valid_o, mask_ready_o); end
   endtask

   initial begin
      test_reset();
      test_stream_8421();
      test_stall();
      test_zero_mask();
      test_full_mask();
      test_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mask_index_serializer.md
Name: mask_index_serializer

Overview:
- Takes a WIDTH-bit mask through a valid/ready handshake and emits the index of every set bit, one per handshake, LSB first.
- Reports the mask's population count and the number of indices still to emit.
- Inverse-direction companion of the popcount tree. Popcount reduces a mask to a count; this block expands a mask back into an index stream.
- Used by issue/arbitration logic to walk request vectors, e.g. FPU lane masks or pending-operand masks.

Parameters:
- WIDTH, 16, mask width in bits; legal range ≥ 2.
- IdxWidth, $clog2(WIDTH), localparam, width of an emitted index.
- CntWidth, $clog2(WIDTH)+1, localparam, width of the count outputs; holds value WIDTH.

Ports:
- clk_i, input, 1, clock.
- rst_ni, input, 1, asynchronous active-low reset.
- flush_i, input, 1, synchronous abort of the current mask.
- mask_i, input, WIDTH, mask to serialize.
- mask_valid_i, input, 1, mask_i is valid.
- mask_ready_o, output, 1, block accepts a mask this cycle.
- idx_o, output, IdxWidth, index of the lowest remaining set bit.
- idx_valid_o, output, 1, idx_o is valid.
- idx_ready_i, input, 1, downstream takes idx_o.
- idx_last_o, output, 1, idx_o is the final index of the current mask.
- count_o, output, CntWidth, popcount of the mask being serialized; held until the next accept.
- remaining_o, output, CntWidth, indices not yet handshaken, including the current idx_o.
- zero_mask_o, output, 1, one-cycle pulse: an all-zero mask was accepted.

Behaviour:
- Reset (rst_ni=0, asynchronous): state=IDLE, mask_q=0, count_q=0, remaining_q=0, zero_mask_o=0. All outputs derived from these are 0 except mask_ready_o=1.
- States: IDLE, ITER.
- mask_ready_o = (state==IDLE) & ~flush_i. It depends on no other input, so there is no combinational ready_i→ready_o path.
- Accept in IDLE (mask_valid_i & mask_ready_o):
  - Nonzero mask: mask_q←mask_i, count_q←popcount(mask_i), remaining_q←same value; next state ITER.
  - Zero mask: count_q←0, remaining_q←0; state stays IDLE; zero_mask_o=1 in the following cycle only.
- ITER outputs:
  - idx_valid_o=1.
  - idx_o = position of the lowest set bit of mask_q.
  - idx_last_o = (remaining_q==1).
  - mask_ready_o=0.
- Index handshake (idx_valid_o & idx_ready_i):
  - Clear that bit in mask_q; remaining_q decrements by 1.
  - If idx_last_o was 1, next state is IDLE. This costs one bubble cycle before the next mask can be accepted.
- Stall: while idx_valid_o & ~idx_ready_i, idx_o, idx_last_o and remaining_o hold stable. idx_valid_o never drops without a handshake or a flush.
- Throughput: one index per cycle under continuous idx_ready_i. A mask with N set bits occupies N cycles in ITER, then IDLE for ≥1 cycle.
- Latency: the first index is visible the cycle after the mask is accepted.
- IDLE outputs: idx_valid_o=0, idx_o=0, idx_last_o=0.
- flush_i (synchronous, highest priority):
  - Next state IDLE; mask_q←0; remaining_q←0; count_q held.
  - An index handshake in the same cycle is discarded.
  - No mask is accepted in a flush cycle.
- Full-mask boundary: mask_i all ones gives count_o=WIDTH, and WIDTH indices are emitted in order 0..WIDTH-1.
- Single-bit boundary: idx_last_o=1 on the first index.
- Arithmetic: count and remaining are unsigned, CntWidth wide, and never wrap. remaining_q==0 only in IDLE.

Decomposition:
- Shared package is not needed. IdxWidth and CntWidth are local. The state enum is local to the module.
- Sub-module: instantiate the existing popcount with INPUT_WIDTH=WIDTH, fed by mask_i, to compute count at accept.
- Lowest-set-bit priority encoder: inline combinational loop, no separate module.

Test Plan:
- Reset, WIDTH=16: assert rst_ni=0 mid-ITER, then release -> mask_ready_o=1, idx_valid_o=0, count_o=0, remaining_o=0 immediately on assertion.
- Accept mask 0x8421 with idx_ready_i=1:
  - Indices 0,5,10,15 on consecutive cycles.
  - count_o=4; remaining_o 4,3,2,1.
  - idx_last_o only with index 15.
  - mask_ready_o returns to 1 one cycle later.
- Mask 0x0006 with idx_ready_i held low 3 cycles -> idx_o=1 stable with remaining_o=2; after release, idx_o=2 with idx_last_o=1.
- Zero mask 0x0000 accepted -> zero_mask_o=1 for exactly one cycle, no idx_valid_o, count_o=0, ready stays 1.
- Mask 0xFFFF -> count_o=16 (0b10000), 16 indices 0..15, 16 ITER cycles.
- flush_i after the 2nd index of 0x00F0:
  - Next cycle IDLE; remaining_o=0; count_o=4.
  - No further indices.
  - Mask 0x0001 offered during the flush cycle is not accepted; it is accepted the next cycle.
